// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge.
// FSM states, slave-index width and response bundle.
package apb_pkg;

  localparam int SEL_W  = 4;
  localparam int RSP_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
  } apb_state_e;

  typedef struct packed {
    logic [RSP_DW-1:0] rdata;
    logic              err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Slave address decoder for the APB master bridge.
// Maps the 4-bit index field to a one-hot select.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 3,
  parameter int SEL_LSB = 8,
  parameter int ADDR_W  = 12
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               dec_err
);

  logic [SEL_W-1:0] idx;
  logic             unused_addr;

  assign idx         = addr[SEL_LSB +: SEL_W];
  assign unused_addr = ^addr;

  // Extra bit keeps NUM_SLV=16 from wrapping.
  assign dec_err =
    {1'b0, idx} >= (SEL_W+1)'(NUM_SLV);

  // One select line per implemented slave.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      sel[i] = (idx == SEL_W'(i));
  end

endmodule

// File: rtl/apb_master_nslv.sv
// APB3/APB4 master bridge from the LSU to N slaves.
// One request in flight, back-to-back capable.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata
);

  localparam int CNT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_err;
  logic               rdy_sel;
  logic               err_sel;
  logic               to_hit;
  logic               done;
  logic               accept;
  logic [DATA_W-1:0]  rdata_sel;

  apb_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB),
    .ADDR_W  (ADDR_W)
  ) u_dec (
    .addr    (req_addr),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // psel stays one-hot through ACCESS, so it
  // doubles as the response mux select.
  assign rdy_sel = |(pready & psel);
  assign err_sel = |(pslverr & psel);

  // Read data from the currently selected slave.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (psel[i])
        rdata_sel = rdata_sel
                  | prdata[i*DATA_W +: DATA_W];
  end

  if (TIMEOUT == 0) begin : g_no_to
    assign to_hit = 1'b0;
  end else begin : g_to
    // Last permitted ACCESS cycle.
    assign to_hit = (cnt == CNT_W'(TIMEOUT-1));
  end

  assign done = (state == ACCESS)
              && (rdy_sel || to_hit);
  assign req_ready = (state == IDLE) || done;
  assign accept    = req_valid && req_ready;

  // FSM, APB outputs, timeout counter, response.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: ;
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= rdy_sel ? err_sel : 1'b1;
            rsp_rdata <=
              (rdy_sel && !err_sel && !pwrite)
              ? rdata_sel : '0;
            psel      <= '0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DECERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new request overrides the IDLE
      // fall-through of a completing transfer.
      if (accept) begin
        pwrite  <= req_write;
        paddr   <= req_addr;
        pwdata  <= req_wdata;
        pstrb   <= req_write ? req_strb : '0;
        penable <= 1'b0;
        psel    <= dec_err ? '0 : dec_sel;
        state   <= dec_err ? DECERR : SETUP;
      end
    end
  end

endmodule
